ws281x_pixel_fifo: RTL

//  Per-port pixel buffer between the ws281x register block and one ws281x_driver.
//  The register block pushes 24-bit GRB pixel words. The driver pops them through its

---
 rtl/ws281x_pixel_fifo.sv | 84 ++++++++
 1 files changed

// File: rtl/ws281x_pixel_fifo.sv
// Pixel FIFO between the ws281x register block and one ws281x_driver.
// First-word-fall-through: rd_data always shows the head entry while dval is high.
module ws281x_pixel_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 24
) (
    input  logic          mclk,
    input  logic          h_reset,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          full,
    output logic [AW:0]   level,
    input  logic [AW:0]   lowmark_thr,
    output logic          lowmark,
    input  logic          ovf_clr,
    output logic          ovf_sticky,
    input  logic          unf_clr,
    output logic          unf_sticky,
    input  logic          data_rd,
    output logic          dval,
    output logic [DW-1:0] rd_data
);

    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          ovf_event;
    logic          unf_event;

    assign full    = (level == DEPTH_L);
    assign dval    = (level != '0);
    assign lowmark = (level < lowmark_thr);
    assign rd_data = mem[rd_ptr];

    // A full FIFO still takes a word when the driver frees a slot in the same cycle.
    assign push      = wr_en & (~full | data_rd) & ~flush;
    assign pop       = data_rd & dval & ~flush;
    assign ovf_event = wr_en & full & ~data_rd & ~flush;
    assign unf_event = data_rd & ~dval & ~flush;

    always_ff @(posedge mclk) begin
        if (push && !h_reset) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge mclk) begin
        if (h_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            ovf_sticky <= 1'b0;
            unf_sticky <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    level <= level + 1'b1;
                end else if (pop && !push) begin
                    level <= level - 1'b1;
                end
            end
            // Set beats clear when both happen in the same cycle.
            ovf_sticky <= ovf_event | (ovf_sticky & ~ovf_clr);
            unf_sticky <= unf_event | (unf_sticky & ~unf_clr);
        end
    end

endmodule
